audio_clock_sequencer: RTL and testbench
========================================

Name: audio_clock_sequencer

Overview:
Control block that configures and sequences the audio clock generator for run-time sample-rate changes.
- Accepts a sample-rate request over a valid/ready handshake and looks up the divisors in a fixed rate table.
- Mutes the audio path, holds the generator in reset, loads new cmd_reg1/cmd_reg2, then releases the generator.
- Confirms lock by counting lrclk1 edges; times out if they do not arrive.
- Sits between the host register file and the clock generator, in the same clk domain as the generator.

Parameters:
- MUTE_CYCLES, 256, cycles mute is held before the generator enters reset
- HOLD_CYCLES, 16, cycles the generator reset is held low
- LOCK_EDGES, 2, lrclk1 rising edges required to declare lock
- TIMEOUT_CYCLES, 16384, max cycles in LOCK before timeout (counter width 16)

Ports:
- clk  in  1  system clock (same as clock generator)
- reset_n  in  1  synchronous active-low reset
- req_valid  in  1  rate-change request valid
- req_ready  out  1  high only in IDLE
- req_rate1  in  3  rate code, primary (mclk/bclk/lrclk1)
- req_rate2  in  3  rate code, lrclk2
- lrclk1  in  1  monitored generator output, same clock domain, no synchronizer
- cmd_reg1  out  32  [31:24] mclk div, [23:16] bclk div, [15:0] zero
- cmd_reg2  out  32  [15:8] lrclk1 div, [7:0] lrclk2 div, [31:16] zero
- gen_reset_n  out  1  clock generator reset
- mute  out  1  audio path mute
- locked  out  1  generator running at the programmed rate
- done  out  1  one-cycle pulse on lock
- err_invalid  out  1  one-cycle pulse on a rejected request
- err_timeout  out  1  sticky lock-timeout flag

Behaviour:
- Rate table, clk = 49.152 MHz, entries as {mclk, bclk, lrclk}:
  - 0 = 8k: {1, 47, 191}
  - 1 = 16k: {1, 23, 95}
  - 2 = 24k: {1, 15, 63}
  - 3 = 32k: {1, 11, 47}
  - 4 = 48k: {1, 7, 31}
  - 5 = 96k: {1, 3, 15}
  - 6 = 192k: {1, 1, 7}
  - 7 = invalid
- bclk and mclk follow rate1. The lrclk2 divisor is the lrclk entry of rate2.
- States: IDLE, MUTE, HOLD, LOCK.
- Reset:
  - State HOLD with rate 4/4 loaded: cmd_reg1=0x01070000, cmd_reg2=0x00001F1F.
  - gen_reset_n=0, mute=1, locked=0, done=0, err_invalid=0, err_timeout=0, hold counter cleared.
  - The block therefore self-starts at 48k.
- IDLE, accept:
  - Accept when req_valid & req_ready.
  - If either code is 7: err_invalid pulses the next cycle, state stays IDLE, no outputs change.
  - Otherwise: latch codes, clear err_timeout, set locked=0 and mute=1 the next cycle, enter MUTE.
- MUTE: after MUTE_CYCLES cycles, enter HOLD. On entry gen_reset_n=0 and cmd_reg1/cmd_reg2 update on the same cycle.
- HOLD: after HOLD_CYCLES cycles, enter LOCK with gen_reset_n=1 and the edge and timeout counters cleared.
- LOCK:
  - Rising edge = lrclk1 & ~lrclk1_q, with lrclk1_q a registered copy.
  - When the edge count reaches LOCK_EDGES: enter IDLE, locked=1, mute=0, done pulses 1 cycle.
  - If the timeout counter reaches TIMEOUT_CYCLES first: enter IDLE, err_timeout=1, locked=0, mute stays 1, gen_reset_n stays 1.
- A request while busy is not accepted (req_ready=0); the requester holds req_valid.
- cmd_reg outputs only change on HOLD entry, never while gen_reset_n=1.
- reset_n low mid-sequence: the next cycle returns to the reset state regardless of the current state.
- All counters saturate/clear on state entry; no wrap-around.

Decomposition:
- Package audio_clk_pkg holds:
  - rate-code constants
  - divisor-triple struct typedef
  - rate-table function
  - state enum
  - cmd_reg field-position constants
- One sub-module: lrclk_lock_detect (edge detect, edge counter, timeout counter; outputs lock/timeout).

Test Plan:
- Reset released, lrclk1 model driven from a real clock generator → after 16 cycles gen_reset_n=1; at the 2nd lrclk1 edge locked=1, mute=0, done pulses; cmd_reg1=0x01070000, cmd_reg2=0x00001F1F.
- Request rate1=5, rate2=6 → mute=1 the next cycle; 256 cycles later gen_reset_n=0 with cmd_reg1=0x01030000, cmd_reg2=0x00000F07; lock after 2 edges.
- Request rate1=7 → err_invalid pulses once, req_ready stays 1, cmd_regs unchanged, locked unchanged.
- lrclk1 held at 0 after release → after 16384 cycles in LOCK err_timeout=1, locked=0, mute=1; next valid request clears err_timeout.
- req_valid held during a sequence → not accepted until IDLE, then accepted in that first IDLE cycle.
- reset_n low during MUTE → next cycle gen_reset_n=0, mute=1, 48k defaults loaded, sequence restarts.

Source files
------------

// File: rtl/audio_clk_pkg.sv
// Shared definitions for the audio clock sequencer: rate codes, divisor table,
// FSM state encoding and cmd_reg field positions.
package audio_clk_pkg;

  // Sample-rate codes (clk = 49.152 MHz)
  localparam logic [2:0] Rate8k      = 3'd0;
  localparam logic [2:0] Rate16k     = 3'd1;
  localparam logic [2:0] Rate24k     = 3'd2;
  localparam logic [2:0] Rate32k     = 3'd3;
  localparam logic [2:0] Rate48k     = 3'd4;
  localparam logic [2:0] Rate96k     = 3'd5;
  localparam logic [2:0] Rate192k    = 3'd6;
  localparam logic [2:0] RateInvalid = 3'd7;

  // Divisor triple for one table entry
  typedef struct packed {
    logic [7:0] mclk;
    logic [7:0] bclk;
    logic [7:0] lrclk;
  } rate_div_t;

  typedef enum logic [1:0] {
    StIdle,
    StMute,
    StHold,
    StLock
  } state_e;

  // cmd_reg field LSB positions
  localparam int unsigned Cmd1MclkPos   = 24;
  localparam int unsigned Cmd1BclkPos   = 16;
  localparam int unsigned Cmd2Lrclk1Pos = 8;
  localparam int unsigned Cmd2Lrclk2Pos = 0;

  function automatic rate_div_t rate_lookup(input logic [2:0] code);
    rate_div_t d;
    d = '0;
    case (code)
      Rate8k:   d = '{mclk: 8'd1, bclk: 8'd47, lrclk: 8'd191};
      Rate16k:  d = '{mclk: 8'd1, bclk: 8'd23, lrclk: 8'd95};
      Rate24k:  d = '{mclk: 8'd1, bclk: 8'd15, lrclk: 8'd63};
      Rate32k:  d = '{mclk: 8'd1, bclk: 8'd11, lrclk: 8'd47};
      Rate48k:  d = '{mclk: 8'd1, bclk: 8'd7,  lrclk: 8'd31};
      Rate96k:  d = '{mclk: 8'd1, bclk: 8'd3,  lrclk: 8'd15};
      Rate192k: d = '{mclk: 8'd1, bclk: 8'd1,  lrclk: 8'd7};
      default:  d = '0;
    endcase
    return d;
  endfunction

  function automatic logic is_invalid(input logic [2:0] code1, input logic [2:0] code2);
    return (code1 == RateInvalid) || (code2 == RateInvalid);
  endfunction

  // mclk/bclk both follow the primary rate
  function automatic logic [31:0] build_cmd1(input rate_div_t d1);
    return (32'(d1.mclk) << Cmd1MclkPos) | (32'(d1.bclk) << Cmd1BclkPos);
  endfunction

  function automatic logic [31:0] build_cmd2(input rate_div_t d1, input rate_div_t d2);
    return (32'(d1.lrclk) << Cmd2Lrclk1Pos) | (32'(d2.lrclk) << Cmd2Lrclk2Pos);
  endfunction

endpackage

// File: rtl/audio_clock_sequencer_lock.sv
// lrclk_lock_detect: watches lrclk1 while the sequencer is waiting for lock.
// Ports:
//   clk, reset_n  - system clock, synchronous active-low reset
//   active        - high while the sequencer is in LOCK; counters clear otherwise
//   lrclk1        - generator frame clock (same clock domain)
//   lock          - combinational: this cycle's rising edge completes LOCK_EDGES
//   timeout       - combinational: LOCK has lasted TIMEOUT_CYCLES without lock
module lrclk_lock_detect #(
  parameter int unsigned LOCK_EDGES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16384
) (
  input  logic clk,
  input  logic reset_n,
  input  logic active,
  input  logic lrclk1,
  output logic lock,
  output logic timeout
);

  localparam int unsigned EdgeW = $clog2(LOCK_EDGES + 1);

  logic             lrclk1_q;
  logic [EdgeW-1:0] edge_cnt_q;
  logic [15:0]      tmo_cnt_q;
  logic             rise;

  assign rise    = lrclk1 & ~lrclk1_q;
  assign lock    = active & rise & (edge_cnt_q == EdgeW'(LOCK_EDGES - 1));
  // Lock wins if both fall on the same cycle
  assign timeout = active & ~lock & (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lrclk1_q   <= 1'b0;
      edge_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      lrclk1_q <= lrclk1;
      if (!active) begin
        // Held clear outside LOCK so every LOCK entry starts from zero
        edge_cnt_q <= '0;
        tmo_cnt_q  <= '0;
      end else begin
        if (rise && (edge_cnt_q != EdgeW'(LOCK_EDGES))) begin
          edge_cnt_q <= edge_cnt_q + 1'b1;
        end
        if (tmo_cnt_q != 16'hFFFF) begin
          tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/audio_clock_sequencer.sv
// audio_clock_sequencer: sequences a sample-rate change of the audio clock
// generator: mute -> hold generator in reset -> load dividers -> release ->
// wait for lrclk1 lock (or time out).
// Ports:
//   clk, reset_n          - system clock, synchronous active-low reset
//   req_valid/req_ready   - rate-change request handshake (ready only in IDLE)
//   req_rate1, req_rate2  - primary and lrclk2 rate codes
//   lrclk1                - monitored generator output
//   cmd_reg1, cmd_reg2    - divider words for the generator
//   gen_reset_n, mute     - generator reset and audio mute controls
//   locked, done          - lock status and one-cycle lock pulse
//   err_invalid           - one-cycle pulse on a rejected request
//   err_timeout           - sticky lock timeout flag
module audio_clock_sequencer
  import audio_clk_pkg::*;
#(
  parameter int unsigned MUTE_CYCLES    = 256,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned LOCK_EDGES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16384
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_rate1,
  input  logic [2:0]  req_rate2,
  input  logic        lrclk1,
  output logic [31:0] cmd_reg1,
  output logic [31:0] cmd_reg2,
  output logic        gen_reset_n,
  output logic        mute,
  output logic        locked,
  output logic        done,
  output logic        err_invalid,
  output logic        err_timeout
);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  rate1_q;
  logic [2:0]  rate2_q;
  logic        lock_hit;
  logic        timeout_hit;

  assign req_ready = (state_q == StIdle);

  lrclk_lock_detect #(
    .LOCK_EDGES     (LOCK_EDGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_lock (
    .clk     (clk),
    .reset_n (reset_n),
    .active  (state_q == StLock),
    .lrclk1  (lrclk1),
    .lock    (lock_hit),
    .timeout (timeout_hit)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // Reset lands in HOLD with 48k/48k loaded, so the block self-starts
      state_q     <= StHold;
      cnt_q       <= '0;
      rate1_q     <= Rate48k;
      rate2_q     <= Rate48k;
      cmd_reg1    <= build_cmd1(rate_lookup(Rate48k));
      cmd_reg2    <= build_cmd2(rate_lookup(Rate48k), rate_lookup(Rate48k));
      gen_reset_n <= 1'b0;
      mute        <= 1'b1;
      locked      <= 1'b0;
      done        <= 1'b0;
      err_invalid <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_invalid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (is_invalid(req_rate1, req_rate2)) begin
              err_invalid <= 1'b1;
            end else begin
              rate1_q     <= req_rate1;
              rate2_q     <= req_rate2;
              err_timeout <= 1'b0;
              locked      <= 1'b0;
              mute        <= 1'b1;
              cnt_q       <= '0;
              state_q     <= StMute;
            end
          end
        end
        StMute: begin
          if (cnt_q == 16'(MUTE_CYCLES - 1)) begin
            // Dividers change only together with the generator entering reset
            cnt_q       <= '0;
            gen_reset_n <= 1'b0;
            cmd_reg1    <= build_cmd1(rate_lookup(rate1_q));
            cmd_reg2    <= build_cmd2(rate_lookup(rate1_q), rate_lookup(rate2_q));
            state_q     <= StHold;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StHold: begin
          if (cnt_q == 16'(HOLD_CYCLES - 1)) begin
            cnt_q       <= '0;
            gen_reset_n <= 1'b1;
            state_q     <= StLock;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StLock: begin
          if (lock_hit) begin
            locked  <= 1'b1;
            mute    <= 1'b0;
            done    <= 1'b1;
            state_q <= StIdle;
          end else if (timeout_hit) begin
            // Generator left running and muted; host decides what to do
            err_timeout <= 1'b1;
            locked      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StHold;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_clock_sequencer.sv
module tb_audio_clock_sequencer;

  localparam int unsigned MuteCycles    = 256;
  localparam int unsigned HoldCycles    = 16;
  localparam int unsigned LockEdges     = 2;
  localparam int unsigned TimeoutCycles = 16384;
  localparam int          Bound         = 40000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_rate1 = 3'd0;
  logic [2:0]  req_rate2 = 3'd0;
  logic        lrclk1 = 1'b0;
  logic        req_ready;
  logic [31:0] cmd_reg1;
  logic [31:0] cmd_reg2;
  logic        gen_reset_n;
  logic        mute;
  logic        locked;
  logic        done;
  logic        err_invalid;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;
  int rises = 0;
  int gen_cnt = 0;
  logic stall = 1'b0;

  logic [31:0] cur_cmd1;
  logic [31:0] cur_cmd2;
  logic        exp_locked;

  // Reference rate table {bclk, lrclk}; mclk is 1 for every valid code
  int ref_b[8] = '{47, 23, 15, 11, 7, 3, 1, 0};
  int ref_l[8] = '{191, 95, 63, 47, 31, 15, 7, 0};

  typedef struct {
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic        inv;
    logic [31:0] cmd1;
    logic [31:0] cmd2;
  } vec_t;

  vec_t vecs[8];

  audio_clock_sequencer #(
    .MUTE_CYCLES    (MuteCycles),
    .HOLD_CYCLES    (HoldCycles),
    .LOCK_EDGES     (LockEdges),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rate1   (req_rate1),
    .req_rate2   (req_rate2),
    .lrclk1      (lrclk1),
    .cmd_reg1    (cmd_reg1),
    .cmd_reg2    (cmd_reg2),
    .gen_reset_n (gen_reset_n),
    .mute        (mute),
    .locked      (locked),
    .done        (done),
    .err_invalid (err_invalid),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Simple generator: lrclk1 toggles every (lrclk div + 1) clocks once released
  always begin
    @(posedge clk);
    #2;
    if (!gen_reset_n) begin
      lrclk1  = 1'b0;
      gen_cnt = 0;
      rises   = 0;
    end else if (stall) begin
      lrclk1  = 1'b0;
      gen_cnt = 0;
    end else begin
      gen_cnt++;
      if (gen_cnt >= int'(cmd_reg2[15:8]) + 1) begin
        gen_cnt = 0;
        lrclk1  = ~lrclk1;
        if (lrclk1) rises++;
      end
    end
  end

  function automatic logic [31:0] model_cmd1(input int r1);
    return (32'd1 << 24) | (32'(ref_b[r1]) << 16);
  endfunction

  function automatic logic [31:0] model_cmd2(input int r1, input int r2);
    return (32'(ref_l[r1]) << 8) | 32'(ref_l[r2]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Counts clocks until gen_reset_n reaches level, starting at the current negedge
  task automatic wait_gen(input logic level, input int exp_k, input string name);
    int k = 0;
    while (gen_reset_n !== level && k < Bound) begin
      @(negedge clk);
      k++;
    end
    chk(name, k, exp_k);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done !== 1'b1 && k < Bound) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 1);
    chk({tag, "_lrclk_edges"}, rises, LockEdges);
    chk({tag, "_locked"}, {31'd0, locked}, 1);
    chk({tag, "_unmuted"}, {31'd0, mute}, 0);
    chk({tag, "_gen_run"}, {31'd0, gen_reset_n}, 1);
    chk({tag, "_ready"}, {31'd0, req_ready}, 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 0);
  endtask

  task automatic run_req(input logic [2:0] r1, input logic [2:0] r2, input logic exp_inv,
                         input logic [31:0] e1, input logic [31:0] e2, input string tag);
    chk({tag, "_ready_before"}, {31'd0, req_ready}, 1);
    req_valid = 1'b1;
    req_rate1 = r1;
    req_rate2 = r2;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_err_invalid"}, {31'd0, err_invalid}, {31'd0, exp_inv});
    if (exp_inv) begin
      chk({tag, "_inv_ready"}, {31'd0, req_ready}, 1);
      chk({tag, "_inv_cmd1"}, cmd_reg1, cur_cmd1);
      chk({tag, "_inv_cmd2"}, cmd_reg2, cur_cmd2);
      chk({tag, "_inv_locked"}, {31'd0, locked}, {31'd0, exp_locked});
      chk({tag, "_inv_mute"}, {31'd0, mute}, {31'd0, ~exp_locked});
      @(negedge clk);
      chk({tag, "_inv_pulse"}, {31'd0, err_invalid}, 0);
    end else begin
      chk({tag, "_mute"}, {31'd0, mute}, 1);
      chk({tag, "_unlocked"}, {31'd0, locked}, 0);
      chk({tag, "_busy"}, {31'd0, req_ready}, 0);
      chk({tag, "_tmo_clr"}, {31'd0, err_timeout}, 0);
      wait_gen(1'b0, MuteCycles, {tag, "_mute_len"});
      chk({tag, "_cmd1"}, cmd_reg1, e1);
      chk({tag, "_cmd2"}, cmd_reg2, e2);
      cur_cmd1 = e1;
      cur_cmd2 = e2;
      wait_gen(1'b1, HoldCycles, {tag, "_hold_len"});
      wait_done(tag);
      chk({tag, "_cmd1_kept"}, cmd_reg1, cur_cmd1);
      exp_locked = 1'b1;
    end
  endtask

  initial begin
    int k;
    logic early;
    logic [2:0] r1, r2;

    vecs[0] = '{3'd5, 3'd6, 1'b0, 32'h01030000, 32'h00000F07};
    vecs[1] = '{3'd0, 3'd0, 1'b0, 32'h012F0000, 32'h0000BFBF};
    vecs[2] = '{3'd7, 3'd3, 1'b1, 32'h0, 32'h0};
    vecs[3] = '{3'd6, 3'd1, 1'b0, 32'h01010000, 32'h0000075F};
    vecs[4] = '{3'd2, 3'd7, 1'b1, 32'h0, 32'h0};
    vecs[5] = '{3'd3, 3'd2, 1'b0, 32'h010B0000, 32'h00002F3F};
    vecs[6] = '{3'd1, 3'd5, 1'b0, 32'h01170000, 32'h00005F0F};
    vecs[7] = '{3'd4, 3'd4, 1'b0, 32'h01070000, 32'h00001F1F};

    cur_cmd1   = 32'h01070000;
    cur_cmd2   = 32'h00001F1F;
    exp_locked = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd1", cmd_reg1, 32'h01070000);
    chk("rst_cmd2", cmd_reg2, 32'h00001F1F);
    chk("rst_gen_reset_n", {31'd0, gen_reset_n}, 0);
    chk("rst_mute", {31'd0, mute}, 1);
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err_invalid", {31'd0, err_invalid}, 0);
    chk("rst_err_timeout", {31'd0, err_timeout}, 0);
    chk("rst_ready", {31'd0, req_ready}, 0);

    // Self-start at 48k
    reset_n = 1'b1;
    wait_gen(1'b1, HoldCycles, "boot_hold_len");
    wait_done("boot");
    chk("boot_cmd1", cmd_reg1, 32'h01070000);
    chk("boot_cmd2", cmd_reg2, 32'h00001F1F);
    exp_locked = 1'b1;

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      run_req(vecs[i].r1, vecs[i].r2, vecs[i].inv, vecs[i].cmd1, vecs[i].cmd2,
              $sformatf("vec%0d", i));
    end

    // Random requests against the reference table
    for (int i = 0; i < 8; i++) begin
      r1 = 3'($urandom_range(0, 7));
      r2 = 3'($urandom_range(0, 7));
      run_req(r1, r2, (r1 == 3'd7) || (r2 == 3'd7), model_cmd1(int'(r1)),
              model_cmd2(int'(r1), int'(r2)), $sformatf("rnd%0d", i));
    end

    // req_valid held through a whole sequence: next accept on the first IDLE cycle
    req_valid = 1'b1;
    req_rate1 = 3'd5;
    req_rate2 = 3'd5;
    @(negedge clk);
    req_rate1 = 3'd6;
    req_rate2 = 3'd6;
    early = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < Bound) begin
      if (req_ready) early = 1'b1;
      @(negedge clk);
      k++;
    end
    chk("held_busy_ready", {31'd0, early}, 0);
    chk("held_done", {31'd0, done}, 1);
    chk("held_first_cmd1", cmd_reg1, 32'h01030000);
    chk("held_first_cmd2", cmd_reg2, 32'h00000F0F);
    chk("held_idle_ready", {31'd0, req_ready}, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("held_reaccept_mute", {31'd0, mute}, 1);
    chk("held_reaccept_busy", {31'd0, req_ready}, 0);
    chk("held_reaccept_unlocked", {31'd0, locked}, 0);
    wait_gen(1'b0, MuteCycles, "held_mute_len");
    chk("held_cmd1", cmd_reg1, 32'h01010000);
    chk("held_cmd2", cmd_reg2, 32'h00000707);
    cur_cmd1 = 32'h01010000;
    cur_cmd2 = 32'h00000707;
    wait_gen(1'b1, HoldCycles, "held_hold_len");
    wait_done("held");

    // Lock timeout with lrclk1 stuck low
    stall = 1'b1;
    chk("tmo_ready", {31'd0, req_ready}, 1);
    req_valid = 1'b1;
    req_rate1 = 3'd1;
    req_rate2 = 3'd1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("tmo_mute", {31'd0, mute}, 1);
    wait_gen(1'b0, MuteCycles, "tmo_mute_len");
    chk("tmo_cmd1", cmd_reg1, 32'h01170000);
    chk("tmo_cmd2", cmd_reg2, 32'h00005F5F);
    cur_cmd1 = 32'h01170000;
    cur_cmd2 = 32'h00005F5F;
    wait_gen(1'b1, HoldCycles, "tmo_hold_len");
    k = 0;
    while (err_timeout !== 1'b1 && k < Bound) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_len", k, TimeoutCycles);
    chk("tmo_locked", {31'd0, locked}, 0);
    chk("tmo_mute_kept", {31'd0, mute}, 1);
    chk("tmo_gen_run", {31'd0, gen_reset_n}, 1);
    chk("tmo_ready_idle", {31'd0, req_ready}, 1);
    chk("tmo_no_done", {31'd0, done}, 0);
    exp_locked = 1'b0;
    stall = 1'b0;
    run_req(3'd7, 3'd0, 1'b1, 32'h0, 32'h0, "tmo_inv");
    chk("tmo_sticky", {31'd0, err_timeout}, 1);
    run_req(3'd3, 3'd3, 1'b0, 32'h010B0000, 32'h00002F2F, "tmo_recover");

    // Reset during MUTE restarts at 48k
    req_valid = 1'b1;
    req_rate1 = 3'd0;
    req_rate2 = 3'd0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (50) @(negedge clk);
    chk("mrst_in_mute", {31'd0, mute}, 1);
    chk("mrst_gen_running", {31'd0, gen_reset_n}, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mrst_gen_reset_n", {31'd0, gen_reset_n}, 0);
    chk("mrst_mute", {31'd0, mute}, 1);
    chk("mrst_locked", {31'd0, locked}, 0);
    chk("mrst_cmd1", cmd_reg1, 32'h01070000);
    chk("mrst_cmd2", cmd_reg2, 32'h00001F1F);
    chk("mrst_ready", {31'd0, req_ready}, 0);
    reset_n = 1'b1;
    cur_cmd1 = 32'h01070000;
    cur_cmd2 = 32'h00001F1F;
    wait_gen(1'b1, HoldCycles, "mrst_hold_len");
    wait_done("mrst");
    chk("mrst_final_cmd1", cmd_reg1, 32'h01070000);
    chk("mrst_final_cmd2", cmd_reg2, 32'h00001F1F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
